// File: rtl/qc_circular_unshifter.sv
// qc_circular_unshifter
//   Pipelined inverse circular shifter for the QC-LDPC write-back path.
//   Each beat carries a Z-bit block (Z <= MAXZ) that was rotated right by s
//   on the way in; this block rotates it left by s within the low Z bits.
//   The rotation is built from two log-shifters: left by s and right by Z-s.
//   Their OR, masked to Z, is the wrapped result.
//
//   Ports
//     CLK, rst_n            clock, synchronous active-low reset
//     in_valid/in_ready     input handshake (in_ready = global advance)
//     in_data               rotated block, bits >= Z ignored
//     shift_val, z_size     rotation amount s and lifting size Z
//     in_tag                sideband, passed through
//     out_valid/out_ready   output handshake
//     out_data, out_tag     unshifted block and its tag (registered)
//     out_err               beat had Z == 0, Z > MAXZ or s >= Z
//
//   Pipeline: capture (1) + one stage per shift-amount bit + combine (1),
//   so latency is $clog2(MAXZ) + 2 cycles. A single global stall freezes
//   every stage whenever the output holds a beat that is not being taken.

// One log-shifter stage: applies bit IDX of both shift amounts.
module qc_unshift_stage #(
  parameter int MAXZ = 81,
  parameter int TAGW = 8,
  parameter int SW   = 7,
  parameter int ZW   = 7,
  parameter int IDX  = 0
) (
  input  logic            CLK,
  input  logic            advance,
  input  logic [MAXZ-1:0] l_in,
  input  logic [MAXZ-1:0] r_in,
  input  logic [SW-1:0]   samt_in,
  input  logic [SW-1:0]   ramt_in,
  input  logic [ZW-1:0]   z_in,
  input  logic [TAGW-1:0] tag_in,
  input  logic            err_in,
  output logic [MAXZ-1:0] l_out,
  output logic [MAXZ-1:0] r_out,
  output logic [SW-1:0]   samt_out,
  output logic [SW-1:0]   ramt_out,
  output logic [ZW-1:0]   z_out,
  output logic [TAGW-1:0] tag_out,
  output logic            err_out
);
  localparam int STEP = 1 << IDX;

  // Datapath only; validity lives in the top-level vld_pipe.
  always_ff @(posedge CLK) begin
    if (advance) begin
      l_out    <= samt_in[IDX] ? (l_in << STEP) : l_in;
      r_out    <= ramt_in[IDX] ? (r_in >> STEP) : r_in;
      samt_out <= samt_in;
      ramt_out <= ramt_in;
      z_out    <= z_in;
      tag_out  <= tag_in;
      err_out  <= err_in;
    end
  end
endmodule

module qc_circular_unshifter #(
  parameter  int MAXZ = 81,
  parameter  int TAGW = 8,
  localparam int SW   = $clog2(MAXZ),
  localparam int ZW   = $clog2(MAXZ + 1)
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MAXZ-1:0] in_data,
  input  logic [SW-1:0]   shift_val,
  input  logic [ZW-1:0]   z_size,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MAXZ-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);
  function automatic logic [MAXZ-1:0] zmask(input logic [ZW-1:0] z);
    logic [MAXZ-1:0] m;
    for (int i = 0; i < MAXZ; i++) m[i] = (i < int'(z));
    return m;
  endfunction

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Capture-stage decode
  logic [ZW-1:0]   s_ext, z_minus_s;
  logic            legal;
  logic [MAXZ-1:0] d_cap;
  logic [SW-1:0]   s_cap, r_cap;

  assign s_ext     = ZW'(shift_val);
  assign legal     = (z_size != '0) && (z_size <= ZW'(MAXZ)) && (s_ext < z_size);
  assign z_minus_s = z_size - s_ext;
  assign d_cap     = legal ? (in_data & zmask(z_size)) : '0;
  assign s_cap     = legal ? shift_val : '0;
  // With s = 0 the right path would need a shift by Z (> SW bits when MAXZ
  // is a power of two); shifting by 0 instead is harmless since OR-ing the
  // block with itself leaves it unchanged.
  assign r_cap     = (legal && shift_val != '0) ? SW'(z_minus_s) : '0;

  // Stage chain; index 0 is the capture register, index i the output of
  // shift stage i.
  logic [SW:0]     vld_pipe;
  logic [MAXZ-1:0] lsh_w  [SW+1];
  logic [MAXZ-1:0] rsh_w  [SW+1];
  logic [SW-1:0]   samt_w [SW+1];
  logic [SW-1:0]   ramt_w [SW+1];
  logic [ZW-1:0]   z_w    [SW+1];
  logic [TAGW-1:0] tag_w  [SW+1];
  logic            err_w  [SW+1];

  logic [MAXZ-1:0] cap_d_q;
  logic [SW-1:0]   cap_s_q, cap_r_q;
  logic [ZW-1:0]   cap_z_q;
  logic [TAGW-1:0] cap_tag_q;
  logic            cap_err_q;

  always_ff @(posedge CLK) begin
    if (advance) begin
      cap_d_q   <= d_cap;
      cap_s_q   <= s_cap;
      cap_r_q   <= r_cap;
      cap_z_q   <= z_size;
      cap_tag_q <= in_tag;
      cap_err_q <= ~legal;
    end
  end

  assign lsh_w[0]  = cap_d_q;
  assign rsh_w[0]  = cap_d_q;
  assign samt_w[0] = cap_s_q;
  assign ramt_w[0] = cap_r_q;
  assign z_w[0]    = cap_z_q;
  assign tag_w[0]  = cap_tag_q;
  assign err_w[0]  = cap_err_q;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    qc_unshift_stage #(
      .MAXZ(MAXZ), .TAGW(TAGW), .SW(SW), .ZW(ZW), .IDX(i)
    ) u_stage (
      .CLK     (CLK),
      .advance (advance),
      .l_in    (lsh_w[i]),
      .r_in    (rsh_w[i]),
      .samt_in (samt_w[i]),
      .ramt_in (ramt_w[i]),
      .z_in    (z_w[i]),
      .tag_in  (tag_w[i]),
      .err_in  (err_w[i]),
      .l_out   (lsh_w[i+1]),
      .r_out   (rsh_w[i+1]),
      .samt_out(samt_w[i+1]),
      .ramt_out(ramt_w[i+1]),
      .z_out   (z_w[i+1]),
      .tag_out (tag_w[i+1]),
      .err_out (err_w[i+1])
    );
  end

  // Amounts are fully consumed once the last stage has applied its bit.
  logic unused_amt;
  assign unused_amt = ^{samt_w[SW], ramt_w[SW]};

  // Valid shift register and combine/output stage
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (advance) begin
      vld_pipe  <= {vld_pipe[SW-1:0], in_valid};
      out_valid <= vld_pipe[SW];
      out_data  <= (lsh_w[SW] | rsh_w[SW]) & zmask(z_w[SW]) & {MAXZ{~err_w[SW]}};
      out_tag   <= tag_w[SW];
      out_err   <= err_w[SW];
    end
  end
endmodule

// File: tb/tb_qc_circular_unshifter.sv
module tb_qc_circular_unshifter;
  localparam int MAXZ = 81;
  localparam int TAGW = 8;
  localparam int SW   = $clog2(MAXZ);
  localparam int ZW   = $clog2(MAXZ + 1);
  localparam int LAT  = SW + 2;

  logic            CLK = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [MAXZ-1:0] in_data;
  logic [SW-1:0]   shift_val;
  logic [ZW-1:0]   z_size;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [MAXZ-1:0] out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_err;

  qc_circular_unshifter #(.MAXZ(MAXZ), .TAGW(TAGW)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_val(shift_val), .z_size(z_size), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [MAXZ-1:0] data;
    int              z;
    int              s;
    logic [MAXZ-1:0] exp;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic [MAXZ-1:0] data;
    logic [TAGW-1:0] tag;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: out[k] = in[(k - s) mod Z] for k < Z
  function automatic logic [MAXZ-1:0] rotl_model(input logic [MAXZ-1:0] d, input int z, input int s);
    logic [MAXZ-1:0] o = '0;
    if (z < 1 || z > MAXZ || s >= z) return o;
    for (int k = 0; k < z; k++) o[k] = d[(k - s + z) % z];
    return o;
  endfunction

  // Forward shifter: right rotate within Z
  function automatic logic [MAXZ-1:0] rotr_model(input logic [MAXZ-1:0] d, input int z, input int s);
    logic [MAXZ-1:0] o = '0;
    for (int j = 0; j < z; j++) o[j] = d[(j + s) % z];
    return o;
  endfunction

  // Output scoreboard: every transferred beat must match the next expected one.
  always @(negedge CLK) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat: got tag %h with no beat outstanding", out_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_beat", {out_err, out_tag, out_data}, {e.err, e.tag, e.data});
      end
    end
  end

  task automatic send(input logic [MAXZ-1:0] d, input int z, input int s,
                      input logic [TAGW-1:0] tag, input logic [MAXZ-1:0] ed, input logic ee);
    bit ok = 0;
    int tries = 0;
    exp_t e;
    in_valid  = 1'b1;
    in_data   = d;
    z_size    = ZW'(z);
    shift_val = SW'(s);
    in_tag    = tag;
    while (!ok && tries < 100) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      if (ok) begin
        e.data = ed; e.tag = tag; e.err = ee;
        exp_q.push_back(e);
      end
      #1;
      tries++;
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      @(posedge CLK); #1;
      cnt++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Accept edge counts as cycle 1; out_valid must appear after edge LAT.
  task automatic latency_beat(input logic [MAXZ-1:0] d, input int z, input int s,
                              input logic [TAGW-1:0] tag, input logic [MAXZ-1:0] ed);
    int cnt;
    send(d, z, s, tag, ed, 1'b0);
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      @(posedge CLK); #1;
      cnt++;
    end
    check("latency", cnt, LAT);
  endtask

  vec_t tbl[13];

  initial begin
    logic [MAXZ-1:0] ones, one, snap_d;
    logic [TAGW-1:0] snap_t;
    logic            snap_e;
    ones = '1;
    one  = 1;

    tbl[0]  = '{one,                          81, 1,  one << 1,   1'b0};
    tbl[1]  = '{(one << 25) | (one << 80),    27, 5,  one << 3,   1'b0};
    tbl[2]  = '{one,                          27, 27, '0,         1'b1};
    tbl[3]  = '{one << 5,                     27, 4,  one << 9,   1'b0};
    tbl[4]  = '{ones,                         0,  0,  '0,         1'b1};
    tbl[5]  = '{one << 1,                     82, 0,  '0,         1'b1};
    tbl[6]  = '{ones,                         1,  0,  one,        1'b0};
    tbl[7]  = '{one << 80,                    81, 80, one << 79,  1'b0};
    tbl[8]  = '{one,                          81, 80, one << 80,  1'b0};
    tbl[9]  = '{81'h81,                       8,  3,  81'h0C,     1'b0};
    tbl[10] = '{ones,                         4,  0,  81'hF,      1'b0};
    tbl[11] = '{81'h123456789ABCDEF,          81, 0,  81'h123456789ABCDEF, 1'b0};
    tbl[12] = '{one << 26,                    27, 26, one << 25,  1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; shift_val = '0; z_size = '0; in_tag = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_tag",   out_tag,   0);
    check("rst_out_err",   out_err,   0);
    rst_n = 1'b1;
    check("rst_in_ready",  in_ready,  1);

    // Basic rotate with latency measurement
    latency_beat(one, 81, 1, 8'h01, one << 1);
    drain();

    // Directed table, back-to-back
    for (int i = 0; i < 13; i++)
      send(tbl[i].data, tbl[i].z, tbl[i].s, 8'h10 + 8'(i), tbl[i].exp, tbl[i].exp_err);
    drain();

    // Round trip through the forward model at Z = MAXZ
    for (int i = 0; i < 1000; i++) begin
      logic [95:0] r;
      logic [MAXZ-1:0] d;
      int s;
      r = {$urandom, $urandom, $urandom};
      d = r[MAXZ-1:0];
      s = $urandom_range(MAXZ - 1, 0);
      send(rotr_model(d, MAXZ, s), MAXZ, s, 8'(i), d, 1'b0);
    end
    drain();
    // Sanity check that the reference itself inverts the forward model
    check("model_sub_z", rotl_model(rotr_model(81'h1F0F, 27, 11), 27, 11), 81'h1F0F);

    // Backpressure: 12 beats, output stalled for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(81'(i * 3 + 1), 81, i, 8'h40 + 8'(i), rotl_model(81'(i * 3 + 1), 81, i), 1'b0);
      end
      begin
        repeat (10) @(posedge CLK);
        #1;
        out_ready = 1'b0;
        snap_d = out_data; snap_t = out_tag; snap_e = out_err;
        check("stall_out_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
          @(negedge CLK);
          check("stall_in_ready", in_ready, 0);
          check("stall_hold", {out_err, out_tag, out_data}, {snap_e, snap_t, snap_d});
          @(posedge CLK); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-stream reset with 6 beats in flight
    for (int i = 0; i < 6; i++)
      send(81'(i + 7), 81, 2, 8'hA0 + 8'(i), rotl_model(81'(i + 7), 81, 2), 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge CLK); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data",  out_data,  0);
    check("mid_rst_out_tag",   out_tag,   0);
    check("mid_rst_out_err",   out_err,   0);
    latency_beat(one << 3, 81, 77, 8'h5C, rotl_model(one << 3, 81, 77));
    drain();
    repeat (15) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
